// File: rtl/cosim_cycle_stamp_arb.sv
// Free-running 64-bit cycle counter shared by NUM_REQ requesters through a
// round-robin arbiter that returns one captured timestamp per grant.
module cosim_cycle_stamp_arb #(
    parameter int unsigned NUM_REQ                 = 4,
    parameter logic [63:0] CORE_CLOCK_FREQUENCY_HZ = 64'd100_000_000,
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               count_en,
    input  logic               count_clear,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [63:0]        rsp_stamp,
    output logic [63:0]        cycle_count,
    output logic [63:0]        freq_hz
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t       state_q;
    logic [63:0]  cnt_q, cnt_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic         rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [63:0]  rsp_stamp_q;

    logic           permit;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic           handshake;
    logic [NUM_REQ-1:0] req_ready_c;

    always_comb begin
        cnt_d = cnt_q;
        if (count_clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    assign permit = (state_q == IDLE) || rsp_ready;

    // Scan upward from rr_ptr; the first hit wins, so no later index overrides it.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            automatic int idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - int'(NUM_REQ);
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    assign handshake = rst_n && permit && grant_found;

    always_comb begin
        req_ready_c = '0;
        if (handshake) begin
            req_ready_c[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (handshake) begin
            rr_ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_stamp_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        state_q     <= HOLD;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= grant_idx;
                        rsp_stamp_q <= cnt_q;
                    end
                end
                HOLD: begin
                    // Accepting a response and capturing the next one in the same cycle keeps HOLD.
                    if (handshake) begin
                        rsp_id_q    <= grant_idx;
                        rsp_stamp_q <= cnt_q;
                    end else if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_c;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_stamp   = rsp_stamp_q;
    assign cycle_count = cnt_q;
    assign freq_hz     = CORE_CLOCK_FREQUENCY_HZ;

endmodule

// File: tb/tb_cosim_cycle_stamp_arb.sv
// Directed bench for cosim_cycle_stamp_arb: counter, round-robin grants,
// response hold, and asynchronous reset behaviour.
module tb_cosim_cycle_stamp_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        count_en = 1'b0;
    logic        count_clear = 1'b0;
    logic [3:0]  req_valid = 4'b0000;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [63:0] rsp_stamp;
    logic [63:0] cycle_count;
    logic [63:0] freq_hz;

    int checks = 0;
    int failures = 0;

    cosim_cycle_stamp_arb #(
        .NUM_REQ(4),
        .CORE_CLOCK_FREQUENCY_HZ(64'd100_000_000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .count_en(count_en),
        .count_clear(count_clear),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_stamp(rsp_stamp),
        .cycle_count(cycle_count),
        .freq_hz(freq_hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state, with requests present to confirm req_ready is gated.
        #1 rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("rst_count", cycle_count, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
        chk("rst_rsp_stamp", rsp_stamp, 64'd0);
        chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
        chk("freq_hz", freq_hz, 64'd100_000_000);

        repeat (2) @(negedge clk);
        req_valid = 4'b0000;
        rst_n = 1'b1;

        // Ten enabled cycles, then clear wins over enable.
        count_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("count_10", cycle_count, 64'd10);
        count_clear = 1'b1;
        @(negedge clk);
        chk("clear_prio", cycle_count, 64'd0);
        count_clear = 1'b0;

        // Bring the counter to 100 and hold it there.
        repeat (100) @(negedge clk);
        count_en = 1'b0;
        chk("count_100", cycle_count, 64'd100);

        // Single request from id 2, response held while rsp_ready=0.
        req_valid = 4'b0100;
        #1 chk("grant_id2", {60'd0, req_ready}, 64'h4);
        @(negedge clk);
        count_en = 1'b1;
        chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
        chk("hold_id", {62'd0, rsp_id}, 64'd2);
        chk("hold_stamp", rsp_stamp, 64'd100);
        for (int i = 0; i < 5; i++) begin
            #1 chk("hold_no_grant", {60'd0, req_ready}, 64'h0);
            @(negedge clk);
            chk("hold_valid_stable", {63'd0, rsp_valid}, 64'd1);
            chk("hold_id_stable", {62'd0, rsp_id}, 64'd2);
            chk("hold_stamp_stable", rsp_stamp, 64'd100);
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_done", {63'd0, rsp_valid}, 64'd0);

        // rr_ptr is 3: a lone request from id 0 moves it to 1.
        req_valid = 4'b0001;
        #1 chk("grant_id0_wrap", {60'd0, req_ready}, 64'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        chk("wrap_id", {62'd0, rsp_id}, 64'd0);
        @(negedge clk);
        chk("back_idle", {63'd0, rsp_valid}, 64'd0);

        // rr_ptr=1 with requests 3 and 0: id 3 first, then id 0.
        req_valid = 4'b1001;
        #1 chk("rr_first", {60'd0, req_ready}, 64'h8);
        @(negedge clk);
        chk("rr_first_id", {62'd0, rsp_id}, 64'd3);
        #1 chk("rr_second", {60'd0, req_ready}, 64'h1);
        @(negedge clk);
        chk("rr_second_id", {62'd0, rsp_id}, 64'd0);
        req_valid = 4'b0000;
        @(negedge clk);

        // Move rr_ptr to 0 via a grant to id 3.
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);

        // Restart counter at 0, then all four requesting back-to-back.
        count_en = 1'b0;
        count_clear = 1'b1;
        @(negedge clk);
        count_clear = 1'b0;
        count_en = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1 chk("b2b_ready", {60'd0, req_ready}, 64'(4'b0001 << (k % 4)));
            @(negedge clk);
            chk("b2b_valid", {63'd0, rsp_valid}, 64'd1);
            chk("b2b_id", {62'd0, rsp_id}, 64'(k % 4));
            chk("b2b_stamp", rsp_stamp, 64'(k));
        end
        req_valid = 4'b0000;
        @(negedge clk);
        chk("b2b_idle", {63'd0, rsp_valid}, 64'd0);
        chk("b2b_count", cycle_count, 64'd6);

        // Clear in the grant cycle affects only the counter, not the stamp.
        count_clear = 1'b1;
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        @(negedge clk);
        count_clear = 1'b0;
        req_valid = 4'b0000;
        chk("clr_grant_stamp", rsp_stamp, 64'd6);
        chk("clr_grant_count", cycle_count, 64'd0);
        @(negedge clk);
        chk("pre_rst_count", cycle_count, 64'd1);
        chk("pre_rst_valid", {63'd0, rsp_valid}, 64'd1);

        // Asynchronous reset mid-HOLD, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("arst_count", cycle_count, 64'd0);
        chk("arst_stamp", rsp_stamp, 64'd0);
        chk("arst_id", {62'd0, rsp_id}, 64'd0);

        // Counter wrap from 2^64-2.
        count_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1 release dut.cnt_q;
        chk("wrap_load", cycle_count, 64'hFFFF_FFFF_FFFF_FFFE);
        count_en = 1'b1;
        @(negedge clk);
        chk("wrap_max", cycle_count, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("wrap_zero", cycle_count, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cosim_cycle_stamp_arb.md
COSIM_CYCLE_STAMP_ARB -- requirements
Module: cosim_cycle_stamp_arb

Interface
REQ-001 The block SHALL have a parameter NUM_REQ, default 4, giving the number of requesters sharing the cycle counter; legal range is 2..16.
REQ-002 The block SHALL have a parameter CORE_CLOCK_FREQUENCY_HZ, default 100_000_000, giving the core clock frequency in Hz, passed through to freq_hz.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port count_en, input, 1 bit: when high, the counter advances.
REQ-006 The block SHALL have port count_clear, input, 1 bit: synchronous counter clear.
REQ-007 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester timestamp request.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester grant, at most one bit high.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: a timestamp response is presented.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-011 The block SHALL have port rsp_id, output, clog2(NUM_REQ) bits: index of the granted requester.
REQ-012 The block SHALL have port rsp_stamp, output, 64 bits: the captured cycle count.
REQ-013 The block SHALL have port cycle_count, output, 64 bits: the live counter value.
REQ-014 The block SHALL have port freq_hz, output, 64 bits: constant CORE_CLOCK_FREQUENCY_HZ.

Function
REQ-015 The counter SHALL be 64-bit unsigned: count_clear=1 loads 0 (priority over count_en); otherwise count_en=1 adds 1; otherwise it holds.
REQ-016 The counter SHALL wrap from 2^64-1 to 0 with no flag or stall.
REQ-017 The FSM SHALL have two states: IDLE (rsp_valid=0) and HOLD (rsp_valid=1).
REQ-018 Grant is permitted in a cycle when state=IDLE, or when state=HOLD and rsp_ready=1.
REQ-019 In a permitted cycle with any req_valid high, the block SHALL assert exactly one req_ready bit, combinationally. The bit SHALL be the first set req_valid bit found searching upward from rr_ptr, wrapping modulo NUM_REQ.
REQ-020 A request handshake SHALL occur when req_valid[i]=1 and req_ready[i]=1.
REQ-021 req_ready SHALL be all-zero when no grant is permitted. req_ready SHALL be all-zero when req_valid is all-zero.
REQ-022 On a handshake of requester g, rsp_stamp SHALL capture cycle_count as it is in that cycle (the pre-update value). On the same handshake, rsp_id SHALL capture g, rr_ptr SHALL become (g+1) mod NUM_REQ, and the state SHALL become HOLD.
REQ-023 Latency SHALL be exactly 1 cycle: rsp_valid rises on the edge after the request handshake.
REQ-024 In HOLD, rsp_valid, rsp_id and rsp_stamp SHALL remain stable until rsp_ready=1.
REQ-025 In HOLD with rsp_ready=1 and a new handshake in the same cycle, the state SHALL remain HOLD with the new id/stamp, giving back-to-back responses at 1 per cycle.
REQ-026 In HOLD with rsp_ready=1 and no request, the state SHALL return to IDLE.
REQ-027 rr_ptr SHALL be unchanged in cycles without a handshake, so a requester that is waiting is served within NUM_REQ grants.
REQ-028 count_clear or count_en in the grant cycle SHALL affect only the next counter value, never the captured stamp.
REQ-029 req_valid deasserted without a handshake SHALL be legal and SHALL have no effect.

Reset
REQ-030 While rst_n=0 (asynchronous assertion), the block SHALL drive: cycle_count=0, state=IDLE, rsp_valid=0, rsp_id=0, rsp_stamp=0, rr_ptr=0, req_ready=0.
REQ-031 Reset asserted in HOLD SHALL discard the pending response without a handshake.
REQ-032 After rst_n deasserts, the first counter increment and the first grant SHALL occur on the first rising clk edge.

Verification
REQ-033 Reset, count_en=1 for 10 cycles -> cycle_count=10. Then count_clear=1 together with count_en=1 -> cycle_count=0 on the next cycle.
REQ-034 Counter forced to 2^64-2, count_en=1 for 2 cycles -> cycle_count reads 2^64-1, then 0.
REQ-035 NUM_REQ=4, rr_ptr=0, req_valid=4'b1111 held, rsp_ready=1 -> grants to ids 0,1,2,3,0 in consecutive cycles. Stamps strictly increase by 1 with count_en=1.
REQ-036 Single request from id 2 at cycle_count=100, rsp_ready=0 for 5 cycles -> rsp_valid is stable with id=2, stamp=100. req_ready=0 throughout the hold. The response completes when rsp_ready=1.
REQ-037 req_valid=4'b1001 with rr_ptr=1 -> id 3 is granted first, then id 0.
REQ-038 rst_n=0 asynchronously mid-HOLD -> rsp_valid=0 and cycle_count=0 immediately, without waiting for a clock edge.
